soc_system_pio_in_edge: RTL and testbench

Parametrised successor to the input-only PIO slave on the HPS lightweight bus: samples a WIDTH-bit asynchronous input port through a configurable synchronizer, exposes the synchronized value, latches per-bit edge events in a write-1-to-clear capture register, and raises a maskable level interrupt. Sits between external status/entropy pins and the Avalon-MM interconnect, and replaces plain read-only PIO instances wherever software needs event detection instead of polling.

---
 rtl/soc_system_pio_in_edge.sv | 121 ++++++++++++
 tb/tb_soc_system_pio_in_edge.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_in_edge.sv
// Input PIO with synchronizer, per-bit edge capture (W1C), maskable level irq; readdata is one cycle behind address.
// Optional 16-bit edge-cycle counter at address 3 when PIO_IN_EDGE_EVENT_CNT_EN is defined.
module soc_system_pio_in_edge #(
  parameter int WIDTH       = 32,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_prev;
  logic [WIDTH-1:0]                  r_mask;
  logic [WIDTH-1:0]                  r_cap;
  logic [2:0]                        r_arm_cnt;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_edge_sel;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_evt_rd;
  logic             w_armed;
  logic             w_write;
  logic             w_unused;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_write  = chipselect & ~write_n;
  assign w_armed  = (r_arm_cnt == ARM_MAX);
  assign w_unused = &{1'b0, writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= w_sync;
    end
  end

  // Hold off detection until the chain has flushed the reset-zeroed values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm_cnt <= '0;
    end else if (!w_armed) begin
      r_arm_cnt <= r_arm_cnt + 3'd1;
    end
  end

  always_comb begin
    w_edge_sel = w_sync ^ r_prev;
    case (EDGE_TYPE)
      0:       w_edge_sel = w_sync & ~r_prev;
      1:       w_edge_sel = ~w_sync & r_prev;
      default: w_edge_sel = w_sync ^ r_prev;
    endcase
  end

  assign w_edge = w_armed ? w_edge_sel : '0;
  assign w_clr  = (w_write && address == 2'd2) ? writedata[WIDTH-1:0] : '0;

  // A new edge overrides a simultaneous clear of the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap  <= '0;
      r_mask <= '0;
    end else begin
      r_cap <= (r_cap & ~w_clr) | w_edge;
      if (w_write && address == 2'd1) begin
        r_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  assign irq = |(r_cap & r_mask);

`ifdef PIO_IN_EDGE_EVENT_CNT_EN
  logic [15:0] r_evt_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_evt_cnt <= '0;
    end else if (w_write && address == 2'd3) begin
      r_evt_cnt <= '0;
    end else if (|w_edge) begin
      r_evt_cnt <= r_evt_cnt + 16'd1;
    end
  end

  assign w_evt_rd = {16'd0, r_evt_cnt};
`else
  assign w_evt_rd = 32'd0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= 32'(w_sync);
        2'd1:    readdata <= 32'(r_mask);
        2'd2:    readdata <= 32'(r_cap);
        default: readdata <= w_evt_rd;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_system_pio_in_edge.sv
// Directed bench: 32-bit rising-edge instance (a) and 8-bit any-edge instance (b).
module tb_soc_system_pio_in_edge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs_a, cs_b, write_n;
  logic [31:0] writedata;
  logic [31:0] in_a;
  logic [7:0]  in_b;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;
  logic [31:0] d;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  soc_system_pio_in_edge #(.WIDTH(32), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_a), .irq(irq_a)
  );

  soc_system_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b),
    .in_port(in_b), .irq(irq_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising clock edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel_b, input logic [1:0] a, input logic [31:0] dat);
    cs_a      = !sel_b;
    cs_b      = sel_b;
    write_n   = 1'b0;
    address   = a;
    writedata = dat;
    @(posedge clk);
    #1;
    cs_a    = 1'b0;
    cs_b    = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(input bit sel_b, input logic [1:0] a, output logic [31:0] dat);
    address = a;
    @(posedge clk);
    #1;
    dat = sel_b ? rd_b : rd_a;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_a      = 32'hFFFF_FFFF;
    in_b      = 8'h00;
    cs_a      = 1'b0;
    cs_b      = 1'b0;
    write_n   = 1'b1;
    address   = 2'd0;
    writedata = 32'd0;
    idle(2);
    check("reset_irq", {31'd0, irq_a}, 32'd0);
    check("reset_readdata", rd_a, 32'd0);
    reset_n = 1'b1;
    idle(10);

    rd(0, 2'd2, d); check("arm_no_spurious_cap", d, 32'd0);
    check("arm_irq", {31'd0, irq_a}, 32'd0);
    rd(0, 2'd0, d); check("arm_data", d, 32'hFFFF_FFFF);

    // Rising edge on bit0, latency to capture/irq
    in_a = 32'd0;
    idle(5);
    wr(0, 2'd1, 32'h1);
    in_a = 32'h1;
    idle(2);
    check("rise_irq_early", {31'd0, irq_a}, 32'd0);
    idle(1);
    check("rise_irq", {31'd0, irq_a}, 32'd1);
    rd(0, 2'd2, d); check("rise_cap", d, 32'h1);
    in_a = 32'h0;
    idle(5);
    rd(0, 2'd2, d); check("fall_no_cap", d, 32'h1);

    // W1C and set-wins
    in_a = 32'h5;
    idle(5);
    rd(0, 2'd2, d); check("cap_0x5", d, 32'h5);
    wr(0, 2'd2, 32'h4);
    rd(0, 2'd2, d); check("w1c_bit2", d, 32'h1);
    in_a = 32'h0;
    idle(5);
    in_a = 32'h1;
    idle(2);
    wr(0, 2'd2, 32'h1);
    rd(0, 2'd2, d); check("set_wins", d, 32'h1);
    wr(0, 2'd2, 32'h1);
    rd(0, 2'd2, d); check("w1c_bit0", d, 32'h0);

    // Masking
    in_a = 32'h2;
    idle(5);
    rd(0, 2'd2, d); check("cap_0x2", d, 32'h2);
    check("masked_irq", {31'd0, irq_a}, 32'd0);
    wr(0, 2'd1, 32'h3);
    check("unmask_irq", {31'd0, irq_a}, 32'd1);
    rd(0, 2'd1, d); check("mask_rb", d, 32'h3);
    wr(0, 2'd0, 32'hDEAD_BEEF);
    rd(0, 2'd0, d); check("data_ro", d, 32'h2);
    wr(0, 2'd2, 32'h2);
    check("clr_irq", {31'd0, irq_a}, 32'd0);

    // Any-edge, narrow instance
    in_b = 8'h81;
    idle(5);
    in_b = 8'h01;
    idle(5);
    rd(1, 2'd2, d); check("any_cap", d, 32'h81);
    rd(1, 2'd0, d); check("any_data", d, 32'h01);
    wr(1, 2'd1, 32'hFFFF_FFFF);
    rd(1, 2'd1, d); check("narrow_mask", d, 32'hFF);
    check("any_irq", {31'd0, irq_b}, 32'd1);
    in_b = 8'hFF;
    idle(5);
    rd(1, 2'd0, d); check("narrow_data", d, 32'hFF);

`ifdef PIO_IN_EDGE_EVENT_CNT_EN
    wr(1, 2'd3, 32'd0);
    rd(1, 2'd3, d); check("cnt_clr", d, 32'd0);
    for (int i = 0; i < 32'h10000; i++) begin
      in_b = in_b ^ 8'h01;
      @(posedge clk);
      #1;
    end
    idle(6);
    rd(1, 2'd3, d); check("cnt_wrap", d, 32'd0);
    for (int i = 0; i < 3; i++) begin
      in_b = in_b ^ 8'h01;
      @(posedge clk);
      #1;
    end
    idle(6);
    rd(1, 2'd3, d); check("cnt_3", d, 32'd3);
    wr(1, 2'd3, 32'h1234);
    rd(1, 2'd3, d); check("cnt_wr_clr", d, 32'd0);
`else
    in_b = 8'h00;
    idle(5);
    rd(1, 2'd3, d); check("no_cnt", d, 32'd0);
    wr(1, 2'd3, 32'h5);
    rd(1, 2'd3, d); check("no_cnt_wr", d, 32'd0);
`endif

    // Asynchronous reset mid-operation
    in_a = 32'h3;
    idle(5);
    check("pre_reset_irq", {31'd0, irq_a}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_irq", {31'd0, irq_a}, 32'd0);
    check("async_rd", rd_a, 32'd0);
    check("async_irq_b", {31'd0, irq_b}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(10);
    rd(0, 2'd2, d); check("rearm_cap", d, 32'd0);
    rd(0, 2'd1, d); check("rearm_mask", d, 32'd0);
    rd(0, 2'd0, d); check("rearm_data", d, 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
